// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, command and reply bytes,
// and the host-to-device frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_FIRST,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FAIL
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  // {stop, odd parity, data}, shifted out LSB first
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS2Clk conditioning: 2-flop sync, stability filter, falling-edge pulse.
// Shared by the host transmitter and the keyboard receive path.
module ps2_clk_filter #(
  parameter int unsigned FILT_CYC = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  output logic clk_lvl_o,
  output logic fe_o
);

  localparam int unsigned CW = $clog2(FILT_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous line into the clock domain (idle high)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ps2_clk_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only once it has held for FILT_CYC cycles
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILT_CYC - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filtered level, its previous value and the stability counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  assign clk_lvl_o = filt_q;
  assign fe_o      = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain pull-low enables).
// Optional macro PS2_TX_RETRY_EN: retry NACK/timeout up to MAX_RETRY times.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned INHIBIT_CYC  = 10_000,
  parameter int unsigned START_TO_CYC = 1_500_000,
  parameter int unsigned PKT_TO_CYC   = 200_000,
  parameter int unsigned FILT_CYC     = 8,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       tx_active,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned TMAX =
    (START_TO_CYC > INHIBIT_CYC) ? START_TO_CYC : INHIBIT_CYC;
  localparam int unsigned TW = $clog2(TMAX + 1);
  localparam int unsigned PW = $clog2(PKT_TO_CYC + 1);

  ps2_tx_state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic [9:0]    sh_q, sh_d;
  logic          dsync1_q, dsync2_q;
  logic          clk_lvl, fe;
  logic          abort;
  logic          pkt_exp;
  logic          unused_cfg;

`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_q, retry_d;
`endif

  assign unused_cfg = (CLK_HZ == 0) ^ (MAX_RETRY == 0);

  ps2_clk_filter #(
    .FILT_CYC (FILT_CYC)
  ) u_clk_filt (
    .clk_i     (clk),
    .rst_i     (rst),
    .ps2_clk_i (ps2_clk_i),
    .clk_lvl_o (clk_lvl),
    .fe_o      (fe)
  );

  // Data line only needs synchronising; it is sampled at filtered edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsync1_q <= 1'b1;
      dsync2_q <= 1'b1;
    end else begin
      dsync1_q <= ps2_data_i;
      dsync2_q <= dsync1_q;
    end
  end

  assign pkt_exp = (pkt_q == PW'(PKT_TO_CYC - 1));

  // Next state, timers, shifter and handshake outputs
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pkt_d     = pkt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    sh_d      = sh_q;
    abort     = 1'b0;
    tx_done   = 1'b0;
    tx_err    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          byte_d  = tx_data;
          bit_d   = '0;
          tmr_d   = '0;
          state_d = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (tmr_q == TW'(INHIBIT_CYC - 1)) begin
          tmr_d   = '0;
          bit_d   = '0;
          sh_d    = ps2_frame(byte_q);
          state_d = ST_REQ;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_REQ: begin
        tmr_d   = '0;
        state_d = ST_WAIT_FIRST;
      end
      ST_WAIT_FIRST: begin
        if (fe) begin
          pkt_d   = '0;
          state_d = ST_BITS;
        end else if (tmr_q == TW'(START_TO_CYC - 1)) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_BITS: begin
        pkt_d = pkt_q + 1'b1;
        if (fe) begin
          sh_d  = {1'b1, sh_q[9:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 4'd8) begin
            state_d = ST_ACK;
          end
        end else if (pkt_exp) begin
          abort = 1'b1;
        end
      end
      ST_ACK: begin
        pkt_d = pkt_q + 1'b1;
        if (fe) begin
          if (dsync2_q) begin
            abort = 1'b1;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end else if (pkt_exp) begin
          abort = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        pkt_d = pkt_q + 1'b1;
        if (clk_lvl && dsync2_q) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end else if (pkt_exp) begin
          abort = 1'b1;
        end
      end
      ST_FAIL: begin
        tx_err  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        tmr_d   = '0;
        state_d = ST_INHIBIT;
      end else begin
        state_d = ST_FAIL;
      end
`else
      state_d = ST_FAIL;
`endif
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      pkt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pkt_q   <= pkt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Attempt counter, cleared on every new accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign tx_ready    = (state_q == ST_IDLE);
  assign tx_active   = (state_q != ST_IDLE);
  assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
  assign ps2_data_oe = (state_q == ST_REQ) ||
                       (state_q == ST_WAIT_FIRST) ||
                       ((state_q == ST_BITS) && !sh_q[0]);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
// Honours PS2_TX_RETRY_EN when the design is built with it.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int STO  = 2000;
  localparam int PKT  = 3000;
  localparam int FILT = 2;
  localparam int HALF = 40;
`ifdef PS2_TX_RETRY_EN
  localparam int ATT = 3;
`else
  localparam int ATT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, tx_active;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_HZ       (100_000_000),
    .INHIBIT_CYC  (INH),
    .START_TO_CYC (STO),
    .PKT_TO_CYC   (PKT),
    .FILT_CYC     (FILT),
    .MAX_RETRY    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .tx_active   (tx_active),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_done = 0;
  int   n_err = 0;
  int   n_inh = 0;
  int   last_done = 0;
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (tx_done) begin
      n_done++;
      last_done = cyc;
    end
    if (tx_err) n_err++;
    if (ps2_clk_oe && !oe_prev) n_inh++;
    oe_prev = ps2_clk_oe;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: odd parity bit makes the count of ones over data+parity odd
  function automatic logic odd_par(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [7:0] b, output int t_acc);
    @(negedge clk);
    chk("ready_before_req", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
    @(negedge clk);
    t_acc    = cyc;
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock 11 edges, ACK or NACK
  task automatic dev_frame(input bit nack, input bit glitch,
                           input int stop_after,
                           output logic [9:0] rx, output logic start_lvl,
                           output bit got);
    got       = 1'b0;
    rx        = '0;
    start_lvl = 1'b1;
    for (int i = 0; i < 5000 && !(ps2_clk_oe || ps2_data_oe); i++)
      @(negedge clk);
    for (int i = 0; i < 5000 && !(!ps2_clk_oe && ps2_data_oe); i++)
      @(negedge clk);
    if (ps2_clk_oe || !ps2_data_oe) return;
    got       = 1'b1;
    start_lvl = ps2_data_i;
    wait_cyc(20);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      if (k <= 10) rx[k-1] = ps2_data_i;
      if (k == 10) dev_data = nack;
      if (k == 11) dev_data = 1'b1;
      if (glitch && k == 4) begin
        wait_cyc(10);
        dev_clk = 1'b0;
        @(negedge clk);
        dev_clk = 1'b1;
        wait_cyc(HALF - 11);
      end else begin
        wait_cyc(HALF);
      end
      if (k == stop_after) begin
        dev_data = 1'b1;
        return;
      end
    end
  endtask

  // Full good transaction: request, device ACKs, check frame and pulses
  task automatic send_ok(input logic [7:0] b, input bit glitch,
                         input string tag);
    int         t_acc, d0, e0;
    logic [9:0] rx;
    logic       st;
    bit         got;
    d0 = n_done;
    e0 = n_err;
    request(b, t_acc);
    dev_frame(1'b0, glitch, 0, rx, st, got);
    wait_cyc(30);
    chk({tag, "_got"}, got, 1'b1);
    chk({tag, "_start"}, st, 1'b0);
    chk({tag, "_byte"}, rx[7:0], b);
    chk({tag, "_par"}, rx[8], odd_par(b));
    chk({tag, "_stop"}, rx[9], 1'b1);
    chk({tag, "_done"}, n_done - d0, 1);
    chk({tag, "_err"}, n_err - e0, 0);
    chk({tag, "_lat"}, (last_done - t_acc) > INH, 1'b1);
    chk({tag, "_idle"}, {ps2_clk_oe, ps2_data_oe, tx_active, tx_ready},
        4'b0001);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t_acc, t_end, d0, e0, i0;
    logic [9:0] rx;
    logic       st;
    bit         got;
    logic [7:0] rb;

    wait_cyc(3);
    chk("rst_outputs",
        {ps2_clk_oe, ps2_data_oe, tx_done, tx_err, tx_active, tx_ready},
        6'b000001);
    rst = 1'b0;
    wait_cyc(3);

    send_ok(PS2_CMD_SET_LED, 1'b0, "ed");
    send_ok(PS2_CMD_ENABLE, 1'b0, "f4");
    send_ok(8'h00, 1'b0, "zero");
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_ok(rb, 1'b0, "rand");
    end
    send_ok(8'h5A, 1'b1, "glitch");

    // Device NACKs every attempt
    d0 = n_done;
    e0 = n_err;
    i0 = n_inh;
    request(PS2_CMD_RESET, t_acc);
    for (int a = 0; a < ATT; a++) begin
      dev_frame(1'b1, 1'b0, 0, rx, st, got);
      chk("nack_got", got, 1'b1);
    end
    wait_cyc(30);
    chk("nack_err", n_err - e0, 1);
    chk("nack_done", n_done - d0, 0);
    chk("nack_inhibits", n_inh - i0, ATT);
    chk("nack_idle", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);

    // Device never clocks
    e0 = n_err;
    i0 = n_inh;
    request(PS2_CMD_ENABLE, t_acc);
    for (int i = 0; i < 10000 && !tx_err; i++) @(negedge clk);
    t_end = cyc;
    chk("to_err_seen", tx_err, 1'b1);
    chk("to_latency", t_end - t_acc, ATT * (INH + STO + 1));
    wait_cyc(2);
    chk("to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("to_inhibits", n_inh - i0, ATT);

    // Reset while bits are being shifted
    request(8'hAB, t_acc);
    dev_frame(1'b0, 1'b0, 4, rx, st, got);
    chk("rst_mid_active", tx_active, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(2);
    chk("rst_mid_ready", tx_ready, 1'b1);
    send_ok(PS2_CMD_RESET, 1'b0, "ff_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
